// File: rtl/thread_cmd_issuer.sv
// Thread-command initiator: queues RUN/STOP requests, issues them one at a time to the
// threads manager with timeout and retry, and returns one in-order response per request.
`ifndef THREAD_CMD_RUN
`define THREAD_CMD_RUN 4'h1
`endif
`ifndef THREAD_CMD_STOP
`define THREAD_CMD_STOP 4'h2
`endif

module thread_cmd_issuer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic [3:0]        thrd_cmd,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              mgr_ack,
  input  logic [1:0]        thrd_rslt,
  input  logic [DATA_W-1:0] mgr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_ok,
  output logic              rsp_tmo,
  output logic [DATA_W-1:0] rsp_data
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT);
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef struct packed {
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  // RETRY is the one-cycle idle gap on the command bus between attempts
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETRY, S_RESP} state_t;

  state_t             state, state_d;
  req_t               mem [DEPTH];
  req_t               head, cur, cur_d;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push, pop;
  logic [TMR_W-1:0]   timer, timer_d;
  logic [RTY_W-1:0]   retry, retry_d;
  logic               timeout, retry_last;
  logic [3:0]         cmd_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [DATA_W-1:0]  data_d, rsp_data_d;
  logic               rsp_valid_d, rsp_ok_d, rsp_tmo_d;
  logic               unused_rslt;

  assign unused_rslt = thrd_rslt[1];
  assign head        = mem[rd_ptr];
  assign pop         = (state == S_IDLE) && (count != '0);
  assign req_ready   = (count != CNT_W'(DEPTH)) || pop;
  assign push        = req_valid && req_ready;
  assign timeout     = (timer == TMR_W'(TIMEOUT - 1));
  assign retry_last  = (retry == RTY_W'(MAX_RETRY));

  // request FIFO storage (contents are don't-care while count says empty)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: req_op, addr: req_addr, data: req_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
      if (pop)  rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
      case ({push, pop})
        2'b10:   count <= CNT_W'(count + CNT_W'(1));
        2'b01:   count <= CNT_W'(count - CNT_W'(1));
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:  if (count != '0) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mgr_ack)      state_d = S_RESP;
        else if (timeout) state_d = retry_last ? S_RESP : S_RETRY;
      end
      S_RETRY: state_d = S_ISSUE;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // next values of the in-flight context and of every registered output
  always_comb begin
    cur_d      = cur;
    retry_d    = retry;
    timer_d    = timer;
    rsp_ok_d   = rsp_ok;
    rsp_tmo_d  = rsp_tmo;
    rsp_data_d = rsp_data;
    cmd_d      = '0;
    addr_d     = '0;
    data_d     = '0;
    unique case (state)
      S_IDLE: begin
        if (pop) begin
          cur_d   = head;
          retry_d = '0;
        end
      end
      S_ISSUE: timer_d = '0;
      S_WAIT: begin
        timer_d = TMR_W'(timer + TMR_W'(1));
        if (mgr_ack) begin
          rsp_ok_d   = thrd_rslt[0];
          rsp_tmo_d  = 1'b0;
          rsp_data_d = mgr_data;
        end else if (timeout) begin
          if (!retry_last) begin
            retry_d = RTY_W'(retry + RTY_W'(1));
          end else begin
            rsp_ok_d   = 1'b0;
            rsp_tmo_d  = 1'b1;
            rsp_data_d = '0;
          end
        end
      end
      default: ;
    endcase
    if ((state_d == S_ISSUE) || (state_d == S_WAIT)) begin
      cmd_d  = cur_d.op ? `THREAD_CMD_STOP : `THREAD_CMD_RUN;
      addr_d = cur_d.addr;
      data_d = cur_d.op ? '0 : cur_d.data;
    end
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur       <= '0;
      retry     <= '0;
      timer     <= '0;
      thrd_cmd  <= '0;
      addr_out  <= '0;
      data_out  <= '0;
      rsp_valid <= 1'b0;
      rsp_ok    <= 1'b0;
      rsp_tmo   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      cur       <= cur_d;
      retry     <= retry_d;
      timer     <= timer_d;
      thrd_cmd  <= cmd_d;
      addr_out  <= addr_d;
      data_out  <= data_d;
      rsp_valid <= rsp_valid_d;
      rsp_ok    <= rsp_ok_d;
      rsp_tmo   <= rsp_tmo_d;
      rsp_data  <= rsp_data_d;
    end
  end
endmodule

// File: tb/tb_thread_cmd_issuer.sv
// Scoreboard bench for thread_cmd_issuer: a manager model answers issued commands and a
// response monitor compares each delivered response against the queued expectation.
module tb_thread_cmd_issuer;
  localparam int unsigned TIMEOUT   = 16;
  localparam int unsigned MAX_RETRY = 2;
  localparam logic [3:0]  CMD_RUN   = 4'h1;
  localparam logic [3:0]  CMD_STOP  = 4'h2;
  localparam int          NEVER     = 99;

  typedef struct {
    logic        op;
    logic [31:0] addr;
    logic [31:0] data;
    int          ack_att;
    int          ack_wait;
    logic [1:0]  rslt;
    logic [31:0] mdata;
    bit          stray;
  } act_t;

  typedef struct {
    logic        ok;
    logic        tmo;
    logic [31:0] data;
    int          hold;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_op = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  thrd_cmd;
  logic [31:0] addr_out, data_out;
  logic        mgr_ack = 1'b0;
  logic [1:0]  thrd_rslt = '0;
  logic [31:0] mgr_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_ok, rsp_tmo;
  logic [31:0] rsp_data;

  act_t act_q[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   mgr_en = 1'b1;
  bit   mon_busy = 1'b0;

  thread_cmd_issuer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data),
    .thrd_cmd(thrd_cmd), .addr_out(addr_out), .data_out(data_out),
    .mgr_ack(mgr_ack), .thrd_rslt(thrd_rslt), .mgr_data(mgr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ok(rsp_ok),
    .rsp_tmo(rsp_tmo), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic act_t mk(input logic op, input logic [31:0] addr, input logic [31:0] data,
                              input int att, input int wt, input logic [1:0] rslt,
                              input logic [31:0] mdata, input bit stray);
    act_t a;
    a.op = op; a.addr = addr; a.data = data; a.ack_att = att; a.ack_wait = wt;
    a.rslt = rslt; a.mdata = mdata; a.stray = stray;
    return a;
  endfunction

  // Offer one request from a negedge; counts negedges spent blocked by req_ready=0.
  task automatic push_req(input act_t a, input int hold, output int blocked);
    exp_t e;
    blocked = 0;
    req_valid = 1'b1; req_op = a.op; req_addr = a.addr; req_data = a.data;
    while (req_ready !== 1'b1 && blocked < 300) begin
      @(negedge clk);
      blocked++;
    end
    if (req_ready !== 1'b1) begin
      chk("req_accept", 32'(req_ready), 32'd1);
    end else begin
      act_q.push_back(a);
      if (a.ack_att <= int'(MAX_RETRY)) begin
        e.ok = a.rslt[0]; e.tmo = 1'b0; e.data = a.mdata;
      end else begin
        e.ok = 1'b0; e.tmo = 1'b1; e.data = '0;
      end
      e.hold = hold;
      exp_q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || act_q.size() != 0 || mon_busy || rsp_valid || thrd_cmd != 0)
           && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", 32'(n < 2000), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Manager model: follows each command pulse, acks per script, checks the bus.
  initial begin : manager
    act_t        cur;
    int          att, w, last_fall;
    logic [3:0]  prev, ecmd;
    logic [31:0] eaddr, edata;
    bit          ack_now, stable;
    prev = '0; att = 0; last_fall = 0;
    cur = mk(1'b0, '0, '0, NEVER, 0, '0, '0, 1'b0);
    forever begin
      @(negedge clk);
      if (mgr_en && thrd_cmd != 4'h0 && prev == 4'h0) begin
        if (att == 0) begin
          chk("issue_expected", 32'(act_q.size() != 0), 32'd1);
          if (act_q.size() != 0) cur = act_q.pop_front();
        end else begin
          chk("retry_gap", 32'(cyc - last_fall), 32'd1);
        end
        ecmd  = cur.op ? CMD_STOP : CMD_RUN;
        eaddr = cur.addr;
        edata = cur.op ? 32'h0 : cur.data;
        chk("issue_cmd", 32'(thrd_cmd), 32'(ecmd));
        chk("issue_addr", addr_out, eaddr);
        chk("issue_data", data_out, edata);
        ack_now = (att == cur.ack_att);
        w = 0; stable = 1'b1;
        while (thrd_cmd != 4'h0 && w < 64) begin
          if (thrd_cmd !== ecmd || addr_out !== eaddr || data_out !== edata) stable = 1'b0;
          mgr_ack   = ack_now && (w == cur.ack_wait);
          thrd_rslt = cur.rslt;
          mgr_data  = cur.mdata;
          w++;
          @(negedge clk);
        end
        mgr_ack = 1'b0;
        chk("cmd_stable", 32'(stable), 32'd1);
        chk("cmd_width", 32'(w), ack_now ? 32'(cur.ack_wait + 1) : 32'(TIMEOUT + 1));
        last_fall = cyc;
        if (ack_now || att == int'(MAX_RETRY)) att = 0;
        else att++;
        if (ack_now && cur.stray) begin
          mgr_ack = 1'b1; thrd_rslt = ~cur.rslt; mgr_data = ~cur.mdata;
          @(negedge clk);
          mgr_ack = 1'b0;
        end
      end
      prev = thrd_cmd;
    end
  end

  // Response monitor: compares each response, holds rsp_ready low as scripted.
  initial begin : rsp_monitor
    exp_t e;
    bit   stable;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        mon_busy = 1'b1;
        chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp_ok", 32'(rsp_ok), 32'(e.ok));
          chk("rsp_tmo", 32'(rsp_tmo), 32'(e.tmo));
          chk("rsp_data", rsp_data, e.data);
          if (e.hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < e.hold; i++) begin
              @(negedge clk);
              if (rsp_valid !== 1'b1 || rsp_ok !== e.ok || rsp_tmo !== e.tmo ||
                  rsp_data !== e.data || thrd_cmd !== 4'h0) stable = 1'b0;
            end
            chk("rsp_hold_stable", 32'(stable), 32'd1);
          end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 20000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int blk;
    bit quiet;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_thrd_cmd", 32'(thrd_cmd), 32'd0);
    chk("rst_addr_out", addr_out, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_ok", 32'(rsp_ok), 32'd0);
    chk("rst_rsp_tmo", 32'(rsp_tmo), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // RUN acked on the 3rd WAIT cycle with success
    push_req(mk(1'b0, 32'h100, 32'h5, 0, 3, 2'b01, 32'hFFFF_FFFF, 1'b0), 0, blk);
    drain();
    // STOP acked at minimum latency with failure result; no retry
    push_req(mk(1'b1, 32'h300, 32'hDEAD, 0, 1, 2'b00, 32'h1234, 1'b0), 0, blk);
    drain();
    // STOP never acked: three full attempts, then timeout response
    push_req(mk(1'b1, 32'h200, 32'h0, NEVER, 0, 2'b00, 32'h0, 1'b0), 0, blk);
    drain();
    // RUN acked on the second attempt exactly at the timeout cycle: ack wins
    push_req(mk(1'b0, 32'h400, 32'h9, 1, 16, 2'b11, 32'hA5A5, 1'b0), 0, blk);
    drain();
    // Consumer stalls 10 cycles with a stray ack in RESP; queued request must wait
    push_req(mk(1'b0, 32'h500, 32'h7, 0, 2, 2'b01, 32'h77, 1'b1), 10, blk);
    push_req(mk(1'b0, 32'h600, 32'h8, 0, 1, 2'b01, 32'h88, 1'b0), 0, blk);
    drain();
    // FIFO fill: five accepted back-to-back, sixth blocked until the IDLE pop
    for (int i = 0; i < 6; i++) begin
      push_req(mk(1'b0, 32'h1000 + 32'(i), 32'(i), 0, 10, 2'b01, 32'hC0 + 32'(i), 1'b0), 0, blk);
      chk($sformatf("fill_blocked_%0d", i), 32'(blk), (i < 5) ? 32'd0 : 32'd9);
    end
    drain();

    // Reset during WAIT with one more request queued: everything dropped
    mgr_en = 1'b0;
    req_valid = 1'b1; req_op = 1'b0; req_addr = 32'h700; req_data = 32'h11;
    @(negedge clk);
    req_addr = 32'h800; req_data = 32'h22;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_cmd", 32'(thrd_cmd), 32'(CMD_RUN));
    chk("pre_rst_addr", addr_out, 32'h700);
    #2 rst = 1'b0;
    #1;
    chk("arst_thrd_cmd", 32'(thrd_cmd), 32'd0);
    chk("arst_addr_out", addr_out, 32'd0);
    chk("arst_data_out", data_out, 32'd0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (thrd_cmd !== 4'h0 || rsp_valid !== 1'b0) quiet = 1'b0;
    end
    chk("post_rst_quiet", 32'(quiet), 32'd1);
    mgr_en = 1'b1;
    push_req(mk(1'b0, 32'hABC, 32'h3, 0, 5, 2'b01, 32'h55, 1'b0), 0, blk);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
